// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: sequences MULTU/MFHI/MFLO/MTHI/MTLO against a fixed-latency shared multiplier
module hilo_mul_ctrl #(
    parameter int         MUL_LATENCY = 32,
    parameter logic [5:0] MULTU_OP    = 6'd25,
    parameter logic [5:0] MFHI_OP     = 6'd16,
    parameter logic [5:0] MTHI_OP     = 6'd17,
    parameter logic [5:0] MFLO_OP     = 6'd18,
    parameter logic [5:0] MTLO_OP     = 6'd19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  op_funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [5:0]  mul_signal,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_product
);
    localparam int CW = $clog2(MUL_LATENCY + 1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q, mul_a_q, mul_b_q;
    logic [5:0]    mul_signal_q;
    logic          is_mul, is_mfhi, is_mthi, is_mflo, is_mtlo, take;
    always_comb begin
        is_mul   = op_funct == MULTU_OP;
        is_mfhi  = op_funct == MFHI_OP;
        is_mthi  = op_funct == MTHI_OP;
        is_mflo  = op_funct == MFLO_OP;
        is_mtlo  = op_funct == MTLO_OP;
        busy     = state_q != IDLE;
        take     = op_valid & ~busy & ~flush;
        stall    = op_valid & busy & (is_mul | is_mfhi | is_mthi | is_mflo | is_mtlo);
        // reset gating keeps the read port quiet while reset is held low
        rd_valid = take & reset & (is_mfhi | is_mflo);
        rd_data  = rd_valid ? (is_mfhi ? hi_q : lo_q) : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signal_q <= '0;
        end else begin
            mul_signal_q <= '0;
            case (state_q)
                IDLE: begin
                    if (take & is_mul) begin
                        mul_a_q      <= op_a;
                        mul_b_q      <= op_b;
                        mul_signal_q <= MULTU_OP;
                        state_q      <= LOAD;
                    end else if (take & is_mthi) begin
                        hi_q <= op_a;
                    end else if (take & is_mtlo) begin
                        lo_q <= op_a;
                    end
                end
                LOAD: begin
                    state_q <= flush ? IDLE : RUN;
                    cnt_q   <= flush ? '0 : CW'(1);
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CW'(MUL_LATENCY)) begin
                        {hi_q, lo_q} <= mul_product;
                        cnt_q        <= '0;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_signal = mul_signal_q;
endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// tb_hilo_mul_ctrl: table vectors, corner sequences and a random run against a cycle-count reference model
module tb_hilo_mul_ctrl;
    localparam int LAT = 32;
    localparam logic [5:0] F_MULTU = 6'd25, F_MFHI = 6'd16, F_MTHI = 6'd17, F_MFLO = 6'd18, F_MTLO = 6'd19;
    logic        clk = 1'b0, reset = 1'b1, op_valid = 1'b0, flush = 1'b0;
    logic [5:0]  op_funct = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        stall, rd_valid, busy;
    logic [31:0] rd_data, hi, lo, mul_a, mul_b;
    logic [5:0]  mul_signal;
    logic [63:0] mul_product;
    int          tests = 0, fails = 0;
    always #5 clk = ~clk;
    hilo_mul_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_funct(op_funct),
        .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .hi(hi), .lo(lo),
        .mul_signal(mul_signal), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product)
    );
    // Stand-in multiplier: the product is only visible on the single cycle it is due, garbage otherwise
    int          mcnt = 0;
    logic [63:0] mres = '0;
    always @(posedge clk or negedge reset) begin
        if (!reset) mcnt <= 0;
        else if (mul_signal == F_MULTU) begin
            mcnt <= 1;
            mres <= 64'(mul_a) * 64'(mul_b);
        end else if (mcnt == LAT) mcnt <= 0;
        else if (mcnt != 0) mcnt <= mcnt + 1;
    end
    assign mul_product = (mcnt == LAT) ? mres : 64'hA5A5_5A5A_DEAD_BEEF;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic set_op(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic fl);
        op_valid = v; op_funct = f; op_a = a; op_b = b; flush = fl;
    endtask
    task automatic idle_op();
        set_op(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    endtask
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        set_op(1'b1, F_MULTU, a, b, 1'b0);
        #1 chk("launch_no_stall", stall, 0);
        @(negedge clk);
        idle_op();
        #1 chk("launch_pulse", mul_signal, F_MULTU);
        chk("launch_mul_a", mul_a, a);
        chk("launch_mul_b", mul_b, b);
    endtask
    task automatic wait_done(input logic [31:0] ehi, input logic [31:0] elo);
        int nb = 0, np = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            nb++;
            if (mul_signal == F_MULTU) np++;
            @(negedge clk);
            #1;
        end
        chk("busy_cycles", nb, LAT + 1);
        chk("pulse_cycles", np, 1);
        chk("cap_hi", hi, ehi);
        chk("cap_lo", lo, elo);
    endtask
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        launch(a, b);
        wait_done(ehi, elo);
        set_op(1'b1, F_MFLO, 32'd0, 32'd0, 1'b0);
        #1 chk("mflo_valid", rd_valid, 1);
        chk("mflo_data", rd_data, elo);
        chk("mflo_stall", stall, 0);
        set_op(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0);
        #1 chk("mfhi_data", rd_data, ehi);
        idle_op();
    endtask
    typedef struct {
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vt[6];
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int ns;
        logic [5:0] codes[5];
        int rem;
        logic [31:0] m_hi, m_lo, m_a, m_b;
        logic [63:0] pend;
        vt[0] = '{32'd7, 32'd6, 32'h0, 32'h2A};
        vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        vt[2] = '{32'd3, 32'd5, 32'h0, 32'd15};
        vt[3] = '{32'h1_0000, 32'h1_0000, 32'h1, 32'h0};
        vt[4] = '{32'h8000_0000, 32'd2, 32'h1, 32'h0};
        vt[5] = '{32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE};
        codes = '{F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
        // reset state, with an MFHI presented to show the read port stays quiet
        #1 reset = 1'b0;
        set_op(1'b1, F_MFHI, 32'h55, 32'h66, 1'b0);
        repeat (2) @(negedge clk);
        #1 chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        chk("rst_mul_signal", mul_signal, 0);
        idle_op();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) run_mul(vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);
        // MFHI presented at E5 stalls until the product is captured
        @(negedge clk);
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        set_op(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0);
        #1 ns = 0;
        for (int i = 0; i < 100 && stall; i++) begin
            ns++;
            @(negedge clk);
            #1;
        end
        chk("mfhi_stall_cycles", ns, LAT - 4);
        chk("mfhi_after_valid", rd_valid, 1);
        chk("mfhi_after_data", rd_data, 32'hFFFF_FFFE);
        // MTHI in IDLE, then MTLO while busy
        set_op(1'b1, F_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        #1 chk("mthi_no_stall", stall, 0);
        @(negedge clk);
        idle_op();
        #1 chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo_kept", lo, 32'h1);
        launch(32'd2, 32'd3);
        set_op(1'b1, F_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
        #1 ns = 0;
        for (int i = 0; i < 100 && stall; i++) begin
            ns++;
            @(negedge clk);
            #1;
        end
        chk("mtlo_stall_cycles", ns, LAT + 1);
        chk("mtlo_pre_lo", lo, 32'd6);
        @(negedge clk);
        idle_op();
        #1 chk("mtlo_lo", lo, 32'hCAFE_F00D);
        chk("mtlo_hi", hi, 32'h0);
        // flush at cnt=10 leaves hi/lo alone, even once the product appears
        launch(32'd3, 32'd5);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_busy", busy, 0);
        repeat (40) @(negedge clk);
        chk("flush_hilo", {hi, lo}, {32'h0, 32'hCAFE_F00D});
        run_mul(32'd3, 32'd5, 32'h0, 32'd15);
        // asynchronous reset mid-RUN
        launch(32'h1234, 32'h10);
        repeat (20) @(negedge clk);
        set_op(1'b1, F_MULTU, 32'd9, 32'd9, 1'b0);
        #1 chk("pre_rst_stall", stall, 1);
        #2 reset = 1'b0;
        #1 chk("arst_busy", busy, 0);
        chk("arst_stall", stall, 0);
        chk("arst_hilo", {hi, lo}, 0);
        chk("arst_mul_ab", {mul_a, mul_b}, 0);
        chk("arst_mul_signal", mul_signal, 0);
        idle_op();
        @(negedge clk);
        reset = 1'b1;
        ns = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy || hi != 0 || lo != 0) ns++;
        end
        chk("arst_no_capture", ns, 0);
        // back-to-back MULTU: second stalls, then launches on the first IDLE edge
        launch(32'd2, 32'd2);
        set_op(1'b1, F_MULTU, 32'h1_0000, 32'h1_0000, 1'b0);
        #1 ns = 0;
        for (int i = 0; i < 100 && stall; i++) begin
            ns++;
            @(negedge clk);
            #1;
        end
        chk("b2b_stall_cycles", ns, LAT + 1);
        chk("b2b_first_lo", lo, 32'd4);
        chk("b2b_gap", mul_signal, 0);
        @(negedge clk);
        idle_op();
        #1 chk("b2b_pulse", mul_signal, F_MULTU);
        chk("b2b_mul_a", mul_a, 32'h1_0000);
        wait_done(32'h1, 32'h0);
        // random traffic against a remaining-cycles reference model
        m_hi = 32'h1; m_lo = 32'h0; m_a = 32'h1_0000; m_b = 32'h1_0000; rem = 0; pend = '0;
        for (int c = 0; c < 3000; c++) begin
            logic v, fl, bz, mf;
            logic [5:0] f;
            logic [31:0] a, b;
            @(negedge clk);
            v = $urandom_range(0, 9) < 7;
            f = $urandom_range(0, 6) < 5 ? codes[$urandom_range(0, 4)] : 6'($urandom_range(32, 63));
            fl = $urandom_range(0, 39) == 0;
            a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 255);
            b = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 255);
            mf = f == F_MFHI || f == F_MFLO;
            if (fl && mf) v = 1'b0;
            set_op(v, f, a, b, fl);
            bz = rem != 0;
            #1 chk("rnd_busy", busy, bz);
            chk("rnd_stall", stall, v && bz && (f inside {F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO}));
            chk("rnd_rd_valid", rd_valid, v && !bz && mf);
            chk("rnd_rd_data", rd_data, (v && !bz && mf) ? (f == F_MFHI ? m_hi : m_lo) : 32'd0);
            chk("rnd_mul_signal", mul_signal, rem == LAT + 1 ? F_MULTU : 6'd0);
            chk("rnd_hilo", {hi, lo}, {m_hi, m_lo});
            if (bz) chk("rnd_mul_ab", {mul_a, mul_b}, {m_a, m_b});
            if (bz) begin
                if (fl) rem = 0;
                else begin
                    rem--;
                    if (rem == 0) {m_hi, m_lo} = pend;
                end
            end else if (v && !fl) begin
                if (f == F_MULTU) begin
                    rem = LAT + 1; m_a = a; m_b = b; pend = 64'(a) * 64'(b);
                end else if (f == F_MTHI) m_hi = a;
                else if (f == F_MTLO) m_lo = a;
            end
        end
        idle_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hilo_mul_ctrl.md
# hilo_mul_ctrl

Sequencing controller between the EX stage and the shared 32-bit shift-add multiplier. It accepts MULTU, MFHI, MFLO, MTHI and MTLO operations. It launches the multiplier with a one-cycle op-code pulse and counts the fixed multiplier latency. It then captures the 64-bit product into the HI/LO registers and stalls the pipeline whenever an operation needs HI/LO or the multiplier while a multiply is in flight.

## Interface
Parameters:
- MUL_LATENCY, 32, number of clock edges after the launch edge at which mul_product holds the final product.
- MULTU_OP / MFHI_OP / MTHI_OP / MFLO_OP / MTLO_OP, 25 / 16 / 17 / 18 / 19, 6-bit function codes.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- op_valid  in  1  an operation is presented this cycle.
- op_funct  in  6  function code; codes other than the five above are ignored.
- op_a  in  32  multiplicand for MULTU; write data for MTHI/MTLO.
- op_b  in  32  multiplier for MULTU.
- flush  in  1  cancel any in-flight multiply (pipeline squash).
- stall  out  1  hold the presented operation; it is not consumed this cycle.
- rd_valid  out  1  rd_data is valid (MFHI/MFLO consumed this cycle).
- rd_data  out  32  HI or LO read value.
- busy  out  1  a multiply is in flight.
- hi, lo  out  32 each  architectural HI/LO registers.
- mul_signal  out  6  op-code to the multiplier.
- mul_a, mul_b  out  32 each  latched operands to the multiplier.
- mul_product  in  64  multiplier result.

## Operation
- FSM states: IDLE, LOAD, RUN. busy = (state != IDLE).
- IDLE plus MULTU:
  - Accepted on the edge. Latch op_a/op_b into mul_a/mul_b. Go to LOAD.
- LOAD:
  - Lasts exactly one cycle with mul_signal = MULTU_OP.
  - Next edge: RUN with cnt <= 1.
  - mul_signal = 0 in every other state.
- RUN:
  - cnt increments on each edge.
  - On the edge where cnt == MUL_LATENCY: {hi,lo} <= mul_product, cnt <= 0, go to IDLE.
- MTHI/MTLO in IDLE:
  - hi (or lo) <= op_a on the edge.
  - If the same edge is a capture edge, capture wins; this cannot occur because MT* stalls while busy.
- MFHI/MFLO in IDLE:
  - rd_valid = 1 combinationally; rd_data = hi or lo.
  - Otherwise rd_valid = 0, rd_data = 0.
- stall (combinational) = op_valid & busy & funct ∈ {MULTU, MFHI, MTHI, MFLO, MTLO}.
  - Unrecognized codes never stall.
- flush in LOAD or RUN:
  - Next edge: go to IDLE, cnt <= 0. hi/lo are not written.
  - flush has priority over capture on the same edge.
  - flush in IDLE has no effect. An op presented with flush = 1 is not accepted.
- Multiplier width rule: product is unsigned 64-bit. hi = product[63:32], lo = product[31:0].
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE, cnt = 0.
  - hi = lo = 0, mul_a = mul_b = 0, mul_signal = 0.
  - stall = rd_valid = busy = 0, rd_data = 0. No capture occurs.

## Timing
- Let E0 be the acceptance edge of a MULTU.
- mul_signal = 25 between E0 and E1.
- Capture happens at edge E(MUL_LATENCY+1), i.e. E33 by default.
- busy is high for MUL_LATENCY+1 cycles.
- An MFHI/MFLO presented in the cycle after the capture edge reads the new value with no stall.
- A back-to-back MULTU presented while busy stalls. It is accepted on the capture edge's following edge, i.e. the first IDLE cycle; mul_signal returns to 0 for at least one cycle between launches.
- No combinational path from mul_product to any output except through hi/lo registers.

## Test plan
- Reset low, then high. Issue MULTU a=7, b=6 at E0 -> busy=1 for 33 cycles, mul_signal=25 for exactly 1 cycle, at E33 hi=0x00000000, lo=0x0000002A. Then MFLO -> rd_valid=1, rd_data=0x2A same cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MFHI issued at E5 -> stall=1 through the capture cycle, then rd_data=0xFFFFFFFE.
- MTHI op_a=0x12345678 in IDLE -> hi=0x12345678 next edge, no stall. MTLO issued while busy -> stalls until IDLE, then lo updated.
- MULTU 3×5, then flush asserted at cnt=10 -> IDLE next edge, hi/lo unchanged. A subsequent MULTU 3×5 -> lo=15.
- Reset asserted asynchronously at cnt=20 mid-RUN -> all outputs 0 immediately (before next clock). After release, no spurious capture and busy=0.
- Two MULTU back-to-back (2×2, then 0x10000×0x10000) -> second is stalled during the first, launches cleanly. Final hi=0x00000001, lo=0x00000000.
